fetch_stall_ctrl: RTL and testbench

- Central hazard sequencer for the 5-stage pipeline.
- Drives the InstructionFetch stall input plus the IF/ID flush and ID/EX bubble controls.
- Resolves four cases: load-use hazards, multi-cycle execute ops (mult/div/FPU), EX-stage redirects (trap/rfe via IAR), and a halt/resume handshake with the debug/trap logic.
- Keeps a saturating stall-cycle counter for performance checks.

---
 rtl/fetch_stall_ctrl_pkg.sv | 17 +
 rtl/fetch_stall_ctrl_if.sv | 32 +++
 rtl/fetch_stall_ctrl_hazard_detect.sv | 14 +
 rtl/fetch_stall_ctrl.sv | 76 +++++++
 tb/tb_fetch_stall_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stall_ctrl_pkg.sv
// fetch_stall_ctrl_pkg: shared state encodings and constants for the fetch hazard sequencer
package fetch_stall_ctrl_pkg;
    typedef enum logic [2:0] {
        RUN      = 3'd0,
        LU_STALL = 3'd1,
        MC_WAIT  = 3'd2,
        FLUSH    = 3'd3,
        HALT     = 3'd4
    } state_t;

    localparam logic [0:4] REG_ZERO = 5'd0;

    localparam logic [1:0] SR_NONE = 2'd0;
    localparam logic [1:0] SR_LU   = 2'd1;
    localparam logic [1:0] SR_MC   = 2'd2;
    localparam logic [1:0] SR_HALT = 2'd3;
endpackage

// File: rtl/fetch_stall_ctrl_if.sv
// fetch_stall_ctrl_if: pipeline-side inputs and stall/flush controls of the hazard sequencer
interface fetch_stall_ctrl_if #(parameter int CNT_W = 16);
    logic [0:4] id_rs1;
    logic [0:4] id_rs2;
    logic id_uses_rs1;
    logic id_uses_rs2;
    logic ex_is_load;
    logic [0:4] ex_rd;
    logic id_is_mc;
    logic mc_done;
    logic ex_redirect;
    logic halt_req;
    logic resume;
    logic stall;
    logic ifid_flush;
    logic idex_bubble;
    logic mc_start;
    logic mc_timeout;
    logic [0:2] state;
    logic [0:CNT_W-1] stall_cycles;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_is_load, ex_rd,
               id_is_mc, mc_done, ex_redirect, halt_req, resume,
        input  stall, ifid_flush, idex_bubble, mc_start, mc_timeout, state, stall_cycles
    );
    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_is_load, ex_rd,
               id_is_mc, mc_done, ex_redirect, halt_req, resume,
        output stall, ifid_flush, idex_bubble, mc_start, mc_timeout, state, stall_cycles
    );
endinterface

// File: rtl/fetch_stall_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use compare between decode sources and the EX load target
import fetch_stall_ctrl_pkg::*;
module hazard_detect (
    input  logic [0:4] rs1,
    input  logic [0:4] rs2,
    input  logic       uses_rs1,
    input  logic       uses_rs2,
    input  logic       ex_is_load,
    input  logic [0:4] ex_rd,
    output logic       lu
);
    assign lu = ex_is_load && ex_rd != REG_ZERO &&
                ((uses_rs1 && rs1 == ex_rd) || (uses_rs2 && rs2 == ex_rd));
endmodule

// File: rtl/fetch_stall_ctrl.sv
// fetch_stall_ctrl: hazard FSM driving fetch stall, IF/ID flush and ID/EX bubble, with MC watchdog
import fetch_stall_ctrl_pkg::*;
module fetch_stall_ctrl #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input logic clk,
    input logic reset,
    fetch_stall_ctrl_if.slave bus
);
    localparam int WD_W = $clog2(MC_TIMEOUT);

    state_t st;
    logic [WD_W-1:0] wd;
    logic [0:CNT_W-1] cnt;
    logic tmo;
    logic lu;
    logic act;

    hazard_detect u_hd (
        .rs1(bus.id_rs1),
        .rs2(bus.id_rs2),
        .uses_rs1(bus.id_uses_rs1),
        .uses_rs2(bus.id_uses_rs2),
        .ex_is_load(bus.ex_is_load),
        .ex_rd(bus.ex_rd),
        .lu(lu)
    );

    // In RUN the lower-priority actions only fire when no redirect or halt preempts them
    always_comb begin
        act = st == RUN && !bus.ex_redirect && !bus.halt_req;
        bus.mc_start = act && bus.id_is_mc;
        bus.stall = (act && (bus.id_is_mc || lu)) || st == MC_WAIT || st == HALT;
        bus.idex_bubble = (act && !bus.id_is_mc && lu) || st == MC_WAIT || st == HALT || st == FLUSH;
        bus.ifid_flush = st == FLUSH;
    end

    assign bus.state = st;
    assign bus.mc_timeout = tmo;
    assign bus.stall_cycles = cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st <= RUN;
            wd <= '0;
            cnt <= '0;
            tmo <= 1'b0;
        end else begin
            if (bus.stall && cnt != '1)
                cnt <= cnt + 1'b1;
            case (st)
                RUN: begin
                    wd <= '0;
                    st <= bus.ex_redirect ? FLUSH : bus.halt_req ? HALT :
                          bus.id_is_mc ? MC_WAIT : lu ? LU_STALL : RUN;
                end
                LU_STALL: st <= bus.ex_redirect ? FLUSH : bus.halt_req ? HALT : RUN;
                MC_WAIT: begin
                    wd <= wd + 1'b1;
                    if (bus.ex_redirect)
                        st <= FLUSH;
                    else if (bus.mc_done)
                        st <= RUN;
                    else if (wd == WD_W'(MC_TIMEOUT - 1)) begin
                        tmo <= 1'b1;
                        st <= RUN;
                    end
                end
                FLUSH: st <= bus.halt_req ? HALT : RUN;
                HALT: st <= (bus.resume && !bus.halt_req) ? RUN : HALT;
                default: st <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// tb_fetch_stall_ctrl: directed vector table plus hand sequences for MC, watchdog, redirect and reset corners
module tb_fetch_stall_ctrl;
    import fetch_stall_ctrl_pkg::*;

    typedef struct {
        logic [0:4] rs1, rs2;
        logic u1, u2, ld;
        logic [0:4] rd;
        logic mc, done, redir, halt, res;
        logic [2:0] st;
        logic stall, flush, bub, start;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int failures = 0;
    vec_t tbl[28];

    fetch_stall_ctrl_if #(.CNT_W(16)) b64 ();
    fetch_stall_ctrl_if #(.CNT_W(16)) b8 ();

    fetch_stall_ctrl #(.MC_TIMEOUT(64), .CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(b64));
    fetch_stall_ctrl #(.MC_TIMEOUT(8), .CNT_W(16)) dut8 (.clk(clk), .reset(reset), .bus(b8));

    assign b8.id_rs1 = b64.id_rs1;
    assign b8.id_rs2 = b64.id_rs2;
    assign b8.id_uses_rs1 = b64.id_uses_rs1;
    assign b8.id_uses_rs2 = b64.id_uses_rs2;
    assign b8.ex_is_load = b64.ex_is_load;
    assign b8.ex_rd = b64.ex_rd;
    assign b8.id_is_mc = b64.id_is_mc;
    assign b8.mc_done = b64.mc_done;
    assign b8.ex_redirect = b64.ex_redirect;
    assign b8.halt_req = b64.halt_req;
    assign b8.resume = b64.resume;

    always #5 clk = ~clk;

    function automatic vec_t v(int rs1, int rs2, int u1, int u2, int ld, int rd, int mc, int done,
                               int redir, int halt, int res, int st, int stall, int flush, int bub, int start);
        vec_t x;
        x.rs1 = 5'(rs1);
        x.rs2 = 5'(rs2);
        x.u1 = 1'(u1);
        x.u2 = 1'(u2);
        x.ld = 1'(ld);
        x.rd = 5'(rd);
        x.mc = 1'(mc);
        x.done = 1'(done);
        x.redir = 1'(redir);
        x.halt = 1'(halt);
        x.res = 1'(res);
        x.st = 3'(st);
        x.stall = 1'(stall);
        x.flush = 1'(flush);
        x.bub = 1'(bub);
        x.start = 1'(start);
        return x;
    endfunction

    task automatic apply(vec_t x);
        b64.id_rs1 = x.rs1;
        b64.id_rs2 = x.rs2;
        b64.id_uses_rs1 = x.u1;
        b64.id_uses_rs2 = x.u2;
        b64.ex_is_load = x.ld;
        b64.ex_rd = x.rd;
        b64.id_is_mc = x.mc;
        b64.mc_done = x.done;
        b64.ex_redirect = x.redir;
        b64.halt_req = x.halt;
        b64.resume = x.res;
    endtask

    task automatic drv(int mc, int done, int redir, int halt, int res);
        apply(v(0, 0, 0, 0, 0, 0, mc, done, redir, halt, res, 0, 0, 0, 0, 0));
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        drv(0, 0, 0, 0, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        // inputs: rs1 rs2 u1 u2 ld rd mc done redir halt res | expected: st stall flush bub start
        tbl[0]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = v(0, 5, 0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        tbl[2]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[3]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = v(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[5]  = v(7, 0, 1, 0, 1, 7, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        tbl[6]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[7]  = v(3, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[8]  = v(3, 0, 1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[9]  = v(0, 5, 0, 1, 1, 5, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        tbl[10] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 1, 1, 0);
        tbl[11] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4, 1, 0, 1, 0);
        tbl[12] = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4, 1, 0, 1, 0);
        tbl[13] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 1, 0, 1, 0);
        tbl[14] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[15] = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[16] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 1, 0);
        tbl[17] = v(0, 5, 0, 1, 1, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        tbl[18] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 1, 0);
        tbl[19] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 1, 0, 1, 0);
        tbl[20] = v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2, 1, 0, 1, 0);
        tbl[21] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[22] = v(0, 5, 0, 1, 1, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        tbl[23] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 1, 0, 1, 0);
        tbl[24] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 1, 0, 1, 0);
        tbl[25] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[26] = v(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[27] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 1, 0);

        do_reset;
        @(negedge clk);
        chk("reset state", int'(b64.state), 0);
        chk("reset stall", int'(b64.stall), 0);
        chk("reset bubble", int'(b64.idex_bubble), 0);
        chk("reset flush", int'(b64.ifid_flush), 0);
        chk("reset mc_start", int'(b64.mc_start), 0);
        chk("reset mc_timeout", int'(b64.mc_timeout), 0);
        chk("reset stall_cycles", int'(b64.stall_cycles), 0);
        tick;

        for (int i = 0; i < 28; i++) begin
            apply(tbl[i]);
            @(negedge clk);
            chk($sformatf("v%0d state", i), int'(b64.state), int'(tbl[i].st));
            chk($sformatf("v%0d stall", i), int'(b64.stall), int'(tbl[i].stall));
            chk($sformatf("v%0d flush", i), int'(b64.ifid_flush), int'(tbl[i].flush));
            chk($sformatf("v%0d bubble", i), int'(b64.idex_bubble), int'(tbl[i].bub));
            chk($sformatf("v%0d mc_start", i), int'(b64.mc_start), int'(tbl[i].start));
            tick;
        end
        chk("table stall_cycles", int'(b64.stall_cycles), 11);
        chk("table mc_timeout", int'(b64.mc_timeout), 0);

        // MC op launched at cycle 0, result at cycle 10
        do_reset;
        for (int c = 0; c < 12; c++) begin
            drv(c == 0, c == 10, 0, 0, 0);
            @(negedge clk);
            chk($sformatf("mc c%0d mc_start", c), int'(b64.mc_start), int'(c == 0));
            chk($sformatf("mc c%0d stall", c), int'(b64.stall), int'(c <= 10));
            chk($sformatf("mc c%0d state", c), int'(b64.state), (c == 0 || c == 11) ? 0 : 2);
            tick;
        end
        chk("mc stall_cycles", int'(b64.stall_cycles), 11);
        chk("mc no timeout", int'(b64.mc_timeout), 0);

        // watchdog on the MC_TIMEOUT=8 instance
        do_reset;
        for (int c = 0; c < 10; c++) begin
            drv(c == 0, 0, 0, 0, 0);
            @(negedge clk);
            chk($sformatf("wd c%0d state", c), int'(b8.state), (c == 0 || c == 9) ? 0 : 2);
            chk($sformatf("wd c%0d mc_timeout", c), int'(b8.mc_timeout), int'(c == 9));
            chk($sformatf("wd c%0d mc_start", c), int'(b8.mc_start), int'(c == 0));
            tick;
        end
        repeat (5) tick;
        @(negedge clk);
        chk("wd sticky mc_timeout", int'(b8.mc_timeout), 1);
        chk("wd sticky state", int'(b8.state), 0);
        tick;

        // redirect at the third MC_WAIT cycle, then a stale mc_done
        do_reset;
        for (int c = 0; c < 8; c++) begin
            drv(c == 0, c == 6, c == 3, 0, 0);
            @(negedge clk);
            chk($sformatf("rd c%0d state", c), int'(b64.state), c == 4 ? 3 : (c >= 1 && c <= 3) ? 2 : 0);
            chk($sformatf("rd c%0d flush", c), int'(b64.ifid_flush), int'(c == 4));
            chk($sformatf("rd c%0d stall", c), int'(b64.stall), int'(c <= 3));
            chk($sformatf("rd c%0d mc_start", c), int'(b64.mc_start), int'(c == 0));
            tick;
        end

        // asynchronous reset while in HALT
        do_reset;
        drv(0, 0, 0, 1, 0);
        tick;
        tick;
        @(negedge clk);
        chk("halt pre state", int'(b64.state), 4);
        chk("halt pre stall", int'(b64.stall), 1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async rst state", int'(b64.state), 0);
        chk("async rst stall", int'(b64.stall), 0);
        chk("async rst bubble", int'(b64.idex_bubble), 0);
        chk("async rst stall_cycles", int'(b64.stall_cycles), 0);

        // saturation: hold HALT for more than 2^16 stall cycles
        do_reset;
        drv(0, 0, 0, 1, 0);
        repeat (65534) tick;
        @(negedge clk);
        chk("sat pre stall_cycles", int'(b64.stall_cycles), 65533);
        repeat (6) tick;
        @(negedge clk);
        chk("sat stall_cycles", int'(b64.stall_cycles), 65535);
        chk("sat state", int'(b64.state), 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
